// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Imported by the interface, the detect sub-module and the top.
package hazard_pkg;

  // Sequencer states: normal running, draining before halt, halted.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_t;

  // Register index of a7 (x17), which carries the ECALL service number.
  localparam int X17_IDX = 17;

  // Service number in x17 that requests program exit.
  localparam int ECALL_EXIT_CODE = 10;

  // x0 is hard-wired to zero, so a load into it never creates a hazard.
  localparam int ZERO_REG = 0;

  // One bundle of pipeline controls.
  // Bit order (MSB first): pc_write, if_id_write, if_id_flush,
  // id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic mem_wb_bubble;
  } pipe_ctrl_t;

  // Everything off: used in reset and once halted.
  localparam pipe_ctrl_t CTRL_OFF    = 7'b000_0000;
  // Every stage advances, no bubbles.
  localparam pipe_ctrl_t CTRL_NORMAL = 7'b110_1010;
  // Whole pipe frozen behind the data memory, MEM/WB gets a NOP.
  localparam pipe_ctrl_t CTRL_FREEZE = 7'b000_0001;
  // Redirect PC, squash IF/ID and ID/EX wrong-path instructions.
  localparam pipe_ctrl_t CTRL_FLUSH  = 7'b111_1110;
  // Hold PC and IF/ID, insert a bubble into EX.
  localparam pipe_ctrl_t CTRL_STALL  = 7'b000_1110;
  // Stop fetching, let older instructions retire downstream.
  localparam pipe_ctrl_t CTRL_DRAIN  = 7'b011_1110;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle of stage decode flags and pipeline controls exchanged between
// the datapath (master) and the hazard controller (slave).
interface pipeline_hazard_controller_if #(
  parameter int REG_ADDR_W = 5,
  parameter int XLEN       = 32,
  parameter int CNT_W      = 32
);

  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic                  id_is_ecall;
  logic [XLEN-1:0]       id_x17_value;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_mem_read;
  logic                  ex_mispredict;
  logic                  dmem_req;
  logic                  dmem_ready;

  logic                  pc_write;
  logic                  if_id_write;
  logic                  if_id_flush;
  logic                  id_ex_write;
  logic                  id_ex_bubble;
  logic                  ex_mem_write;
  logic                  mem_wb_bubble;
  logic                  is_halted;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_ecall, id_x17_value,
           ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_mem_read,
           ex_mispredict, dmem_req, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           ex_mem_write, mem_wb_bubble, is_halted, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_ecall, id_x17_value,
           ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_mem_read,
           ex_mispredict, dmem_req, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           ex_mem_write, mem_wb_bubble, is_halted, stall_cycles, flush_count
  );

endinterface

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// Combinational hazard compare: load-use against the instruction in EX,
// and ECALL reading x17 while an older instruction is still producing it.
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_is_ecall,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_mem_read,
  output logic                  load_use,
  output logic                  ecall_hazard
);

  logic rs1_match;
  logic rs2_match;
  logic ex_writes_x17;
  logic mem_loads_x17;

  // A load in EX cannot forward in time; an ECALL needs x17 settled, which
  // a pending ALU write in EX or a load in MEM would not yet provide.
  always_comb begin
    rs1_match     = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_match     = id_use_rs2 && (id_rs2 == ex_rd);
    load_use      = ex_mem_read && (ex_rd != REG_ADDR_W'(ZERO_REG)) &&
                    (rs1_match || rs2_match);
    ex_writes_x17 = ex_reg_write && (ex_rd == REG_ADDR_W'(X17_IDX));
    mem_loads_x17 = mem_mem_read && (mem_rd == REG_ADDR_W'(X17_IDX));
    ecall_hazard  = id_is_ecall && (ex_writes_x17 || mem_loads_x17);
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush/halt sequencer for the 5-stage pipeline.
// Controls are combinational from the current state and stage flags so a
// hazard is handled in the cycle it appears; state, halt flag and the
// performance counters are registered.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic clk,
  input  logic reset_n,
  pipeline_hazard_controller_if.slave bus
);

  localparam int DCW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  // The ECALL resolve cycle already behaves as the first drain cycle, so
  // the DRAIN state itself lasts DRAIN_CYCLES-1 unfrozen cycles.
  localparam logic [DCW-1:0] DRAIN_LAST =
    (DRAIN_CYCLES < 2) ? '0 : DCW'(DRAIN_CYCLES - 1);

  hz_state_t        state;
  hz_state_t        next_state;
  logic [DCW-1:0]   drain_cnt;
  logic [DCW-1:0]   next_drain_cnt;
  logic [DCW-1:0]   drain_inc;
  logic             is_halted_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic             stall_inc;
  logic             flush_inc;
  logic             freeze;
  logic             exit_request;
  logic             load_use;
  logic             ecall_hazard;
  pipe_ctrl_t       ctrl_raw;
  pipe_ctrl_t       ctrl;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_detect (
    .id_rs1       (bus.id_rs1),
    .id_rs2       (bus.id_rs2),
    .id_use_rs1   (bus.id_use_rs1),
    .id_use_rs2   (bus.id_use_rs2),
    .id_is_ecall  (bus.id_is_ecall),
    .ex_rd        (bus.ex_rd),
    .ex_reg_write (bus.ex_reg_write),
    .ex_mem_read  (bus.ex_mem_read),
    .mem_rd       (bus.mem_rd),
    .mem_mem_read (bus.mem_mem_read),
    .load_use     (load_use),
    .ecall_hazard (ecall_hazard)
  );

  assign freeze       = bus.dmem_req && !bus.dmem_ready;
  assign exit_request = bus.id_is_ecall &&
                        (bus.id_x17_value == XLEN'(ECALL_EXIT_CODE));
  assign drain_inc    = drain_cnt + DCW'(1);

  // Prioritised control selection and next-state logic; freeze outranks
  // everything so a mispredict waits in EX until memory answers.
  always_comb begin
    ctrl_raw       = CTRL_OFF;
    next_state     = state;
    next_drain_cnt = drain_cnt;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    unique case (state)
      RUN: begin
        if (freeze) begin
          ctrl_raw  = CTRL_FREEZE;
          stall_inc = 1'b1;
        end else if (bus.ex_mispredict) begin
          ctrl_raw  = CTRL_FLUSH;
          flush_inc = 1'b1;
        end else if (ecall_hazard) begin
          ctrl_raw  = CTRL_STALL;
          stall_inc = 1'b1;
        end else if (exit_request) begin
          ctrl_raw       = CTRL_DRAIN;
          next_state     = DRAIN;
          next_drain_cnt = '0;
        end else if (load_use) begin
          ctrl_raw  = CTRL_STALL;
          stall_inc = 1'b1;
        end else begin
          ctrl_raw = CTRL_NORMAL;
        end
      end
      DRAIN: begin
        if (freeze) begin
          ctrl_raw  = CTRL_FREEZE;
          stall_inc = 1'b1;
        end else begin
          ctrl_raw       = CTRL_DRAIN;
          next_drain_cnt = drain_inc;
          if (drain_inc >= DRAIN_LAST) begin
            next_state = HALTED;
          end
        end
      end
      HALTED: begin
        ctrl_raw = CTRL_OFF;
      end
      default: begin
        ctrl_raw   = CTRL_OFF;
        next_state = RUN;
      end
    endcase
  end

  // Force every enable and bubble low while reset is held.
  always_comb begin
    ctrl = reset_n ? ctrl_raw : CTRL_OFF;
  end

  // Sequencer state, halt flag and saturating performance counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      drain_cnt   <= '0;
      is_halted_q <= 1'b0;
      stall_q     <= '0;
      flush_q     <= '0;
    end else begin
      state       <= next_state;
      drain_cnt   <= next_drain_cnt;
      is_halted_q <= (next_state == HALTED);
      if (stall_inc && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (flush_inc && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.if_id_write   = ctrl.if_id_write;
  assign bus.if_id_flush   = ctrl.if_id_flush;
  assign bus.id_ex_write   = ctrl.id_ex_write;
  assign bus.id_ex_bubble  = ctrl.id_ex_bubble;
  assign bus.ex_mem_write  = ctrl.ex_mem_write;
  assign bus.mem_wb_bubble = ctrl.mem_wb_bubble;
  assign bus.is_halted     = is_halted_q;
  assign bus.stall_cycles  = stall_q;
  assign bus.flush_count   = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for the pipeline hazard controller. A reference model
// predicts the controls and counters for each driven cycle; predictions
// are queued and compared once the DUT outputs have settled.
module tb_pipeline_hazard_controller;

  localparam int REG_ADDR_W   = 5;
  localparam int XLEN         = 32;
  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 4;

  // Control vector order: pc_write, if_id_write, if_id_flush, id_ex_write,
  // id_ex_bubble, ex_mem_write, mem_wb_bubble.
  localparam logic [6:0] V_OFF    = 7'b000_0000;
  localparam logic [6:0] V_NORMAL = 7'b110_1010;
  localparam logic [6:0] V_FREEZE = 7'b000_0001;
  localparam logic [6:0] V_FLUSH  = 7'b111_1110;
  localparam logic [6:0] V_STALL  = 7'b000_1110;
  localparam logic [6:0] V_DRAIN  = 7'b011_1110;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use1;
    logic        use2;
    logic        ecall;
    logic [31:0] x17;
    logic [4:0]  ex_rd;
    logic        ex_rw;
    logic        ex_mr;
    logic [4:0]  mem_rd;
    logic        mem_mr;
    logic        misp;
    logic        req;
    logic        rdy;
  } stim_t;

  typedef struct {
    string            tag;
    logic [6:0]       ctrl;
    logic             halted;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];

  // Reference model state: 0 run, 1 drain, 2 halted.
  int               m_state = 0;
  int               m_cnt = 0;
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;

  always #5 clk = ~clk;

  pipeline_hazard_controller_if #(
    .REG_ADDR_W (REG_ADDR_W),
    .XLEN       (XLEN),
    .CNT_W      (CNT_W)
  ) bus ();

  pipeline_hazard_controller #(
    .REG_ADDR_W   (REG_ADDR_W),
    .XLEN         (XLEN),
    .DRAIN_CYCLES (DRAIN_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      passed++;
    end
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s.rs1 = '0; s.rs2 = '0; s.use1 = 1'b0; s.use2 = 1'b0;
    s.ecall = 1'b0; s.x17 = '0; s.ex_rd = '0; s.ex_rw = 1'b0;
    s.ex_mr = 1'b0; s.mem_rd = '0; s.mem_mr = 1'b0; s.misp = 1'b0;
    s.req = 1'b0; s.rdy = 1'b0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.id_rs1 = s.rs1;         bus.id_rs2 = s.rs2;
    bus.id_use_rs1 = s.use1;    bus.id_use_rs2 = s.use2;
    bus.id_is_ecall = s.ecall;  bus.id_x17_value = s.x17;
    bus.ex_rd = s.ex_rd;        bus.ex_reg_write = s.ex_rw;
    bus.ex_mem_read = s.ex_mr;  bus.mem_rd = s.mem_rd;
    bus.mem_mem_read = s.mem_mr; bus.ex_mispredict = s.misp;
    bus.dmem_req = s.req;       bus.dmem_ready = s.rdy;
  endtask

  // Predict this cycle's outputs from the model, then advance the model.
  task automatic modelStep(input string tag, input stim_t s, output exp_t e);
    logic fz, lu, eh, ex_exit, bump_s, bump_f;
    fz      = s.req && !s.rdy;
    lu      = s.ex_mr && (s.ex_rd != 5'd0) &&
              ((s.use1 && s.rs1 == s.ex_rd) || (s.use2 && s.rs2 == s.ex_rd));
    eh      = s.ecall && ((s.ex_rw && s.ex_rd == 5'd17) ||
                          (s.mem_mr && s.mem_rd == 5'd17));
    ex_exit = s.ecall && (s.x17 == 32'd10);
    e.tag    = tag;
    e.stall  = m_stall;
    e.flush  = m_flush;
    e.halted = (m_state == 2);
    bump_s   = 1'b0;
    bump_f   = 1'b0;
    if (m_state == 2) begin
      e.ctrl = V_OFF;
    end else if (fz) begin
      e.ctrl = V_FREEZE; bump_s = 1'b1;
    end else if (m_state == 1) begin
      e.ctrl = V_DRAIN;
      m_cnt++;
      if (m_cnt >= DRAIN_CYCLES - 1) m_state = 2;
    end else if (s.misp) begin
      e.ctrl = V_FLUSH; bump_f = 1'b1;
    end else if (eh) begin
      e.ctrl = V_STALL; bump_s = 1'b1;
    end else if (ex_exit) begin
      e.ctrl = V_DRAIN; m_state = 1; m_cnt = 0;
    end else if (lu) begin
      e.ctrl = V_STALL; bump_s = 1'b1;
    end else begin
      e.ctrl = V_NORMAL;
    end
    if (bump_s && m_stall != {CNT_W{1'b1}}) m_stall = m_stall + 1'b1;
    if (bump_f && m_flush != {CNT_W{1'b1}}) m_flush = m_flush + 1'b1;
  endtask

  task automatic compareNext();
    exp_t e;
    logic [6:0] got;
    e   = sb.pop_front();
    got = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_write,
           bus.id_ex_bubble, bus.ex_mem_write, bus.mem_wb_bubble};
    checkOutput({e.tag, ".ctrl"}, 32'(got), 32'(e.ctrl));
    checkOutput({e.tag, ".halted"}, 32'(bus.is_halted), 32'(e.halted));
    checkOutput({e.tag, ".stall"}, 32'(bus.stall_cycles), 32'(e.stall));
    checkOutput({e.tag, ".flush"}, 32'(bus.flush_count), 32'(e.flush));
  endtask

  task automatic applyStimulus(input string tag, input stim_t s);
    exp_t e;
    @(negedge clk);
    drive(s);
    modelStep(tag, s, e);
    sb.push_back(e);
    #1;
    compareNext();
  endtask

  // Reset clears the model; every output must read zero while held.
  task automatic expectReset(input string tag);
    exp_t e;
    m_state = 0; m_cnt = 0; m_stall = '0; m_flush = '0;
    e.tag = tag; e.ctrl = V_OFF; e.halted = 1'b0; e.stall = '0; e.flush = '0;
    sb.push_back(e);
    compareNext();
  endtask

  task automatic asyncReset(input string tag);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 expectReset(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    drive(idleStim());
    #2 expectReset("por");
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus("idle", idleStim());

    // Load-use on rs1, then the same pattern targeting x0.
    s = idleStim(); s.ex_mr = 1; s.ex_rd = 5; s.rs1 = 5; s.use1 = 1;
    applyStimulus("lu_rs1", s);
    applyStimulus("after_lu", idleStim());
    s.ex_rd = 0; s.rs1 = 0;
    applyStimulus("lu_x0", s);

    // Matching register without its use flag, then via rs2.
    s = idleStim(); s.ex_mr = 1; s.ex_rd = 7; s.rs1 = 7; s.use1 = 0;
    applyStimulus("lu_nouse", s);
    s.rs2 = 7; s.use2 = 1;
    applyStimulus("lu_rs2", s);

    // Mispredict beats a simultaneous load-use.
    s = idleStim(); s.ex_mr = 1; s.ex_rd = 5; s.rs1 = 5; s.use1 = 1; s.misp = 1;
    applyStimulus("flush_over_lu", s);

    // Three frozen cycles hold the mispredict, flush once memory answers.
    s = idleStim(); s.misp = 1; s.req = 1; s.rdy = 0;
    for (int i = 0; i < 3; i++) applyStimulus($sformatf("freeze%0d", i), s);
    s.rdy = 1;
    applyStimulus("flush_after_freeze", s);
    applyStimulus("post_freeze", idleStim());

    // ECALL with a non-exit code is a NOP.
    s = idleStim(); s.ecall = 1; s.x17 = 5;
    applyStimulus("ecall_nop", s);
    applyStimulus("ecall_nop_after", idleStim());

    // ECALL waiting on a load of x17 in MEM.
    s = idleStim(); s.ecall = 1; s.x17 = 10; s.mem_mr = 1; s.mem_rd = 17;
    applyStimulus("ecall_mem_hz", s);
    applyStimulus("flush_clear", idleStim());

    // Exit sequence: hazard stall, resolve, drain with a frozen pause, halt.
    asyncReset("rst1");
    s = idleStim(); s.ecall = 1; s.ex_rw = 1; s.ex_rd = 17; s.x17 = 10;
    applyStimulus("ecall_ex_hz", s);
    s.ex_rw = 0; s.ex_rd = 0;
    applyStimulus("ecall_exit", s);
    applyStimulus("drain0", idleStim());
    s = idleStim(); s.req = 1;
    applyStimulus("drain_frozen", s);
    applyStimulus("drain1", idleStim());
    s = idleStim(); s.misp = 1; s.ex_mr = 1; s.ex_rd = 5; s.rs1 = 5; s.use1 = 1;
    applyStimulus("halted0", s);
    applyStimulus("halted1", idleStim());
    checkOutput("halt_hold", 32'(bus.is_halted), 32'd1);

    // Reset while draining returns to RUN with clean counters.
    asyncReset("rst2");
    s = idleStim(); s.ecall = 1; s.x17 = 10;
    applyStimulus("exit_again", s);
    applyStimulus("drain_again", idleStim());
    asyncReset("rst_in_drain");
    applyStimulus("run_after_rst", idleStim());

    // Stall counter saturates at all-ones.
    s = idleStim(); s.ex_mr = 1; s.ex_rd = 3; s.rs2 = 3; s.use2 = 1;
    for (int i = 0; i < 18; i++) applyStimulus($sformatf("sat%0d", i), s);
    applyStimulus("sat_idle", idleStim());
    checkOutput("stall_saturated", 32'(bus.stall_cycles), 32'd15);

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush/halt sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Consumes per-stage decode flags from the control unit and stage registers. Drives write-enables and bubble/flush controls for PC and every pipeline register.
- Detects load-use hazards, applies branch-mispredict flushes and freezes the pipe on data-memory wait.
- Sequences ECALL-exit halt: check x17, drain, then halt. Keeps stall and flush cycle counters.

Parameters:
- REG_ADDR_W, 5, register index width
- XLEN, 32, data width
- DRAIN_CYCLES, 3, cycles to retire EX/MEM/WB contents before halt
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- id_rs1  in  REG_ADDR_W  ID source register 1
- id_rs2  in  REG_ADDR_W  ID source register 2
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- id_is_ecall  in  1  ECALL in ID
- id_x17_value  in  XLEN  forwarded x17 value seen by ID
- ex_rd  in  REG_ADDR_W  EX destination
- ex_reg_write  in  1  EX instruction writes rd
- ex_mem_read  in  1  EX instruction is a load
- mem_rd  in  REG_ADDR_W  MEM destination
- mem_mem_read  in  1  MEM instruction is a load
- ex_mispredict  in  1  EX resolved branch/jump with PC redirect
- dmem_req  in  1  MEM stage has a valid data-memory access
- dmem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID loads NOP
- id_ex_write  out  1  ID/EX register enable
- id_ex_bubble  out  1  ID/EX loads NOP
- ex_mem_write  out  1  EX/MEM register enable
- mem_wb_bubble  out  1  MEM/WB loads NOP
- is_halted  out  1  CPU halted (registered)
- stall_cycles  out  CNT_W  count of load-use, ECALL and memory stall cycles
- flush_count  out  CNT_W  count of applied mispredict flushes

Behaviour:
- States: RUN, DRAIN, HALTED. Reset → RUN, drain counter 0, counters 0, is_halted 0.
- While reset_n is low, all enables and bubbles are 0.
- Priority in RUN, highest first:
  1. freeze
  2. flush
  3. ECALL check
  4. load-use
- freeze = dmem_req & ~dmem_ready.
  - Sets pc_write, if_id_write, id_ex_write and ex_mem_write to 0. Sets mem_wb_bubble to 1.
  - All other controls are 0. A pending ex_mispredict is deferred until the cycle dmem_ready rises. The branch is held in EX.
  - Increments stall_cycles.
- flush = ex_mispredict & ~freeze.
  - if_id_flush=1, id_ex_bubble=1, pc_write=1. Increments flush_count.
  - Overrides any load-use or ECALL condition, because ID holds a wrong-path instruction.
- load-use = ex_mem_read & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - pc_write=0, if_id_write=0, id_ex_bubble=1. Increments stall_cycles.
- ECALL hazard = id_is_ecall & ((ex_reg_write & ex_rd==17) | (mem_mem_read & mem_rd==17)).
  - Stalls exactly like load-use.
- ECALL resolved (id_is_ecall, no hazard, no freeze/flush):
  - If id_x17_value==10: next state DRAIN, drain counter cleared. This cycle: pc_write=0, if_id_flush=1, id_ex_bubble=1.
  - Otherwise ECALL is a NOP and the pipeline advances normally.
- DRAIN:
  - pc_write=0, if_id_flush=1, id_ex_bubble=1, downstream enables normal.
  - freeze still applies and pauses the drain counter.
  - Counter increments each unfrozen cycle. When it reaches DRAIN_CYCLES-1, next state is HALTED.
  - ex_mispredict is ignored; it cannot occur once the instructions ahead of the ECALL have retired.
- HALTED: all enables 0, all bubbles 0, is_halted=1. Exits only on reset.
- Otherwise, in RUN, all enables are 1 and all bubbles/flush are 0.
- Counters saturate at all-ones. A counter increments at most once per cycle.
- Asynchronous reset mid-DRAIN or in HALTED returns to RUN immediately.

Decomposition:
- Package hazard_pkg holds:
  - state enum {RUN, DRAIN, HALTED}
  - constant X17_IDX=17
  - constant ECALL_EXIT_CODE=10
  - constant ZERO_REG=0
- Sub-module hazard_detect: purely combinational load-use and ECALL-x17 hazard compare. Outputs load_use and ecall_hazard.

Test Plan:
- LW x5 in EX, ID ADD reads x5 (use_rs1=1) → 1 cycle pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cycles 0→1. Same with ex_rd=0 → no stall.
- ex_mispredict=1 while the load-use condition is also true → if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_count=1, stall_cycles unchanged.
- dmem_req=1, dmem_ready low 3 cycles, ex_mispredict=1 throughout → 3 freeze cycles (mem_wb_bubble=1, no flush), flush on cycle 4; stall_cycles=3, flush_count=1.
- ECALL in ID, ex_reg_write=1, ex_rd=17, then x17=10 → 1 stall cycle, then DRAIN 3 cycles, is_halted=1 on cycle 5 and held.
- ECALL with id_x17_value=5, no hazard → no stall, state stays RUN, is_halted=0.
- Assert reset_n low during DRAIN → all outputs 0 asynchronously; after release, state RUN, counters 0.
